// File: rtl/spi_master_ctrl.sv
// SPI master issuing 10-bit command frames (one bit per clk) and collecting 8-bit read-data replies.
// Define SPI_MASTER_CTRL_SVA_EN to compile the embedded assertions and covers.
module spi_master_ctrl #(
  parameter int unsigned RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SHIFT,
    ST_WAIT,
    ST_READ
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

  state_t     r_state;
  logic [9:0] r_cmd;
  logic       r_rd;
  logic [3:0] r_cnt;
  logic [7:0] r_sh;
  logic       r_ss_n;
  logic       r_mosi;
  logic       r_busy;
  logic       r_done;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_rd       <= 1'b0;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mosi <= 1'b0;
          if (start) begin
            r_cmd   <= cmd_data;
            r_rd    <= &cmd_data[9:8];
            r_state <= ST_SELECT;
            r_ss_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SELECT: begin
          // r_cmd shifts left so MOSI always takes bit 9 of the remaining payload
          r_mosi  <= r_cmd[9];
          r_cmd   <= {r_cmd[8:0], 1'b0};
          r_cnt   <= 4'd9;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_cnt == 4'd0) begin
            r_mosi <= 1'b0;
            if (!r_rd) begin
              r_state <= ST_IDLE;
              r_ss_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (RD_WAIT > 0) begin
              r_cnt   <= LP_WAIT_LAST;
              r_state <= ST_WAIT;
            end else begin
              r_cnt   <= 4'd7;
              r_state <= ST_READ;
            end
          end else begin
            r_mosi <= r_cmd[9];
            r_cmd  <= {r_cmd[8:0], 1'b0};
            r_cnt  <= r_cnt - 4'd1;
          end
        end
        ST_WAIT: begin
          r_mosi <= 1'b0;
          if (r_cnt == 4'd0) begin
            r_cnt   <= 4'd7;
            r_state <= ST_READ;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_READ: begin
          r_mosi <= 1'b0;
          r_sh   <= {r_sh[6:0], MISO};
          if (r_cnt == 4'd0) begin
            r_rd_data  <= {r_sh[6:0], MISO};
            r_rd_valid <= 1'b1;
            r_state    <= ST_IDLE;
            r_ss_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ss_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign SS_n     = r_ss_n;
  assign MOSI     = r_mosi;

`ifdef SPI_MASTER_CTRL_SVA_EN
  // Length of the current/just-finished SS_n low run; zeroed by reset so aborted frames are skipped
  logic [5:0] r_sva_len;

  always_ff @(posedge clk) begin
    if (rst)        r_sva_len <= '0;
    else if (!SS_n) r_sva_len <= r_sva_len + 6'd1;
    else            r_sva_len <= '0;
  end

  a_low_len: assert property (@(posedge clk)
    ($rose(SS_n) && r_sva_len != 6'd0) |->
      (r_sva_len == (r_rd ? 6'(19 + RD_WAIT) : 6'd11)));
  a_busy_ss: assert property (@(posedge clk) busy == !SS_n);
  a_done_pulse: assert property (@(posedge clk) done |=> !done);
  a_rv_done: assert property (@(posedge clk) rd_valid |-> done);
  a_reset_vals: assert property (@(posedge clk)
    rst |=> (SS_n && !MOSI && !busy && !done && !rd_valid && rd_data == 8'h00));

  c_read_frame: cover property (@(posedge clk) rd_valid);
  c_back_to_back: cover property (@(posedge clk) done && start ##1 !SS_n);
`endif

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-clock SPI master that generates the 10-bit command frames consumed by the SPI slave/RAM wrapper: drives `SS_n` and `MOSI`, and for read-data commands collects the 8-bit reply from `MISO`. It sits between a host-side request interface (`start`/`cmd_data`) and the slave's serial pins. Serial bits advance once per `clk` cycle, with no separate SCLK. It is the initiator for the command frames the slave already decodes (`00` write address, `01` write data, `10` read address, `11` read data).

## Interface
- `RD_WAIT`, 2: idle cycles (`SS_n` low) between the last command bit and the first `MISO` sample in a read-data frame; legal range 0..15.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request; accepted only when `busy`=0.
- `cmd_data` in 10: frame payload, sent MSB first; `[9:8]` is the command code, `[7:0]` is address/data; captured on the accept cycle.
- `busy` out 1: frame in progress; high exactly while `SS_n`=0.
- `done` out 1: one-cycle pulse in the first cycle `SS_n` returns high.
- `rd_data` out 8: byte received in the last read-data frame; held until the next read-data frame completes.
- `rd_valid` out 1: one-cycle pulse coincident with `done` for read-data (`11`) frames only.
- `SS_n` out 1: slave select, active low.
- `MOSI` out 1: serial data to the slave.
- `MISO` in 1: serial data from the slave.

## Operation
- States: `IDLE`, `SELECT`, `SHIFT`, `WAIT`, `READ`.
- `IDLE`: `SS_n`=1, `MOSI`=0. On `start`, latch `cmd_data` and go to `SELECT`.
- `SELECT`: one cycle with `SS_n`=0 and `MOSI`=0 (don't-care to the slave); go to `SHIFT`.
- `SHIFT`: 10 cycles; `MOSI` = `cmd[9]` down to `cmd[0]`.
  - If `cmd[9:8]`≠`11`, go to `IDLE`.
  - If `cmd[9:8]`=`11` and `RD_WAIT`>0, go to `WAIT`.
  - If `cmd[9:8]`=`11` and `RD_WAIT`=0, go to `READ`.
- `WAIT`: `RD_WAIT` cycles; `SS_n`=0, `MOSI`=0; then go to `READ`.
- `READ`: 8 cycles; sample `MISO` MSB first into a shift register; `MOSI`=0; then go to `IDLE`, loading `rd_data` and pulsing `rd_valid`.
- `done` pulses on every `→IDLE` transition out of a frame.
- One 4-bit down-counter is shared by `SHIFT`, `WAIT` and `READ`. There are no other arithmetic paths.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` in the `done` cycle is accepted. This gives exactly one `SS_n`-high cycle between frames, which is the minimum gap.
- `rst` mid-frame:
  - Next cycle: `SS_n`=1, state `IDLE`.
  - No `done` or `rd_valid` is issued.
  - `rd_data` is cleared.
- `rst` takes precedence over a coincident `start`.
- Reset values: `SS_n`=1, `MOSI`=0, `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0.

## Timing
- Accept at cycle A (`start`=1, `busy`=0).
- Cycle T=A+1: `SS_n` falls, `busy` rises.
- Cycles T+1..T+10: command bits on `MOSI`.
- Write-address / write-data / read-address frames: `SS_n` high and `done`=1 at T+11. Frame length is 11 low cycles.
- Read-data frames:
  - `MISO` sampled at T+11+`RD_WAIT` .. T+18+`RD_WAIT`, MSB first.
  - `SS_n` high, `done`=1 and `rd_valid`=1 at T+19+`RD_WAIT`.
  - `rd_data` valid from that cycle onward.
- All outputs are registered; no combinational path from `MISO` or `start` to any output.

## Configuration
- `SPI_MASTER_CTRL_SVA_EN` defined: embedded assertions and covers are compiled in:
  - `SS_n` low run is exactly 11 cycles, or 19+`RD_WAIT` for cmd `11`.
  - `busy` == ~`SS_n`.
  - `done` is a single-cycle pulse.
  - `rd_valid` implies `done`.
  - The cycle after `rst` shows all reset values.
- Undefined: no assertion code. Functional behaviour is identical.

## Test plan
- Reset check: `rst`=1 for 2 cycles -> `SS_n`=1, `MOSI`=0, `busy`/`done`/`rd_valid`=0, `rd_data`=0x00.
- Write address: `start` with `cmd_data`=0x0A5 ->
  - `SS_n` low 11 cycles.
  - `MOSI` sequence after the select cycle is 0,0,1,0,1,0,0,1,0,1.
  - `done` at T+11; `rd_valid`=0.
- Read data, `RD_WAIT`=2: `cmd_data`=0x300, model drives `MISO`=0x3C bits at T+13..T+20 -> `rd_data`=0x3C and `rd_valid`=`done`=1 at T+21; `SS_n` low 21 cycles.
- Back-to-back: `start` (write data 0x1FF) asserted in the `done` cycle of a prior frame -> `SS_n` high exactly 1 cycle, new frame bits 0,1,1,1,1,1,1,1,1,1.
- Reset mid-frame: `rst` at T+5 of a read-data frame -> `SS_n`=1 next cycle, no `done`/`rd_valid`, `rd_data`=0x00; a subsequent `start` behaves normally.
- Ignored start: `start` pulsed at T+3 with `cmd_data`=0x2FF during a 0x0A5 frame -> transmitted bits unchanged, single `done`.
